// File: rtl/ym3438_ch_mixer.sv
// Six-channel left/right mixer for the time-multiplexed YM3438 channel DAC stream.
// Accumulates one frame of offset-binary channel values per pan bit and emits a saturated sample per frame.
module ym3438_ch_mixer #(
  parameter int OUT_WIDTH = 12
) (
  input  logic                        MCLK,
  input  logic                        reset,
  input  logic                        c1,
  input  logic                        sync,
  input  logic [8:0]                  ch_out,
  input  logic [1:0]                  ch_pan,
  output logic signed [OUT_WIDTH-1:0] out_l,
  output logic signed [OUT_WIDTH-1:0] out_r,
  output logic                        sample_valid,
  output logic                        frame_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic signed [16:0] SAT_MAX = 17'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [16:0] SAT_MIN = 17'(-(1 << (OUT_WIDTH - 1)));

  logic [1:0]                  state_q, state_d;
  logic [2:0]                  cnt_q, cnt_d;
  logic signed [11:0]          acc_l_q, acc_l_d;
  logic signed [11:0]          acc_r_q, acc_r_d;
  logic signed [OUT_WIDTH-1:0] out_l_q, out_l_d;
  logic signed [OUT_WIDTH-1:0] out_r_q, out_r_d;
  logic                        valid_q, valid_d;
  logic                        err_q, err_d;

  logic signed [8:0]  ch_val;
  logic signed [11:0] con_l, con_r;
  logic signed [11:0] sum_l, sum_r;

  // Clamp to the output range; for OUT_WIDTH >= 12 the clamp never fires and this is a sign extension.
  function automatic logic [OUT_WIDTH-1:0] saturate(input logic signed [11:0] x);
    logic signed [16:0] x_ext;
    x_ext = 17'(x);
    if (x_ext > SAT_MAX) begin
      x_ext = SAT_MAX;
    end else if (x_ext < SAT_MIN) begin
      x_ext = SAT_MIN;
    end
    return x_ext[OUT_WIDTH-1:0];
  endfunction

  assign ch_val = {~ch_out[8], ch_out[7:0]};
  assign con_l  = ch_pan[1] ? 12'(ch_val) : 12'sd0;
  assign con_r  = ch_pan[0] ? 12'(ch_val) : 12'sd0;
  assign sum_l  = acc_l_q + con_l;
  assign sum_r  = acc_r_q + con_r;

  always_comb begin
    // NOTE: every next-state signal takes a default first so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    out_l_d = out_l_q;
    out_r_d = out_r_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    if (c1) begin
      case (state_q)
        S_RUN: begin
          if (sync) begin
            err_d   = 1'b1;
            acc_l_d = con_l;
            acc_r_d = con_r;
            cnt_d   = 3'd1;
          end else if (cnt_q == 3'd5) begin
            out_l_d = saturate(sum_l);
            out_r_d = saturate(sum_r);
            valid_d = 1'b1;
            cnt_d   = 3'd0;
            state_d = S_HOLD;
          end else begin
            acc_l_d = sum_l;
            acc_r_d = sum_r;
            cnt_d   = cnt_q + 3'd1;
          end
        end
        default: begin
          // IDLE and HOLD both wait for a sync tick to open a frame.
          if (sync) begin
            acc_l_d = con_l;
            acc_r_d = con_r;
            cnt_d   = 3'd1;
            state_d = S_RUN;
          end
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      acc_l_q <= '0;
      acc_r_q <= '0;
      out_l_q <= '0;
      out_r_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      out_l_q <= out_l_d;
      out_r_q <= out_r_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign out_l        = out_l_q;
  assign out_r        = out_r_q;
  assign sample_valid = valid_q;
  assign frame_err    = err_q;

endmodule

// File: tb/tb_ym3438_ch_mixer.sv
// Directed bench for ym3438_ch_mixer: a 12-bit and a 9-bit (saturating) instance share one input stream.
module tb_ym3438_ch_mixer;

  logic        MCLK = 1'b0;
  logic        reset = 1'b0;
  logic        c1 = 1'b0;
  logic        sync = 1'b0;
  logic [8:0]  ch_out = 9'h100;
  logic [1:0]  ch_pan = 2'b00;

  logic signed [11:0] out_l, out_r;
  logic signed [8:0]  out_l9, out_r9;
  logic               sample_valid, frame_err;
  logic               sample_valid9, frame_err9;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_err = 0;

  always #5 MCLK = ~MCLK;

  ym3438_ch_mixer #(.OUT_WIDTH(12)) dut (
    .MCLK(MCLK), .reset(reset), .c1(c1), .sync(sync), .ch_out(ch_out), .ch_pan(ch_pan),
    .out_l(out_l), .out_r(out_r), .sample_valid(sample_valid), .frame_err(frame_err)
  );

  ym3438_ch_mixer #(.OUT_WIDTH(9)) dut9 (
    .MCLK(MCLK), .reset(reset), .c1(c1), .sync(sync), .ch_out(ch_out), .ch_pan(ch_pan),
    .out_l(out_l9), .out_r(out_r9), .sample_valid(sample_valid9), .frame_err(frame_err9)
  );

  // Pulse counters sampled mid-cycle: a pulse stuck high for two cycles counts twice.
  always @(negedge MCLK) begin
    if (sample_valid) n_valid++;
    if (frame_err) n_err++;
  end

  task automatic do_tick(input logic s, input logic [8:0] v, input logic [1:0] p, input int gap);
    repeat (gap) @(negedge MCLK);
    @(negedge MCLK);
    c1 = 1'b1; sync = s; ch_out = v; ch_pan = p;
    @(posedge MCLK);
    #1;
    c1 = 1'b0; sync = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    checks++;
    if (out_l !== 12'sd0 || out_r !== 12'sd0 || sample_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out_l=%0d out_r=%0d valid=%b err=%b, expected 0 0 0 0",
               out_l, out_r, sample_valid, frame_err);
    end
    repeat (2) @(negedge MCLK);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) do_tick(1'b0, 9'h1FF, 2'b11, 0);
    repeat (2) @(negedge MCLK);
    checks++;
    if (n_valid !== 0 || out_l !== 12'sd0) begin
      errors++;
      $display("FAIL idle_ignores_ticks: valid_pulses=%0d out_l=%0d, expected 0 0", n_valid, out_l);
    end
  endtask

  task automatic test_full_scale();
    int v0 = n_valid;
    for (int i = 0; i < 6; i++) begin
      do_tick(i == 0, 9'h1FF, 2'b11, 0);
      if (i == 4) begin
        checks++;
        if (sample_valid !== 1'b0 || n_valid !== v0) begin
          errors++;
          $display("FAIL full_scale_early_valid: valid=%b pulses=%0d, expected no pulse yet", sample_valid, n_valid - v0);
        end
      end
    end
    checks++;
    if (sample_valid !== 1'b1 || out_l !== 12'sd1530 || out_r !== 12'sd1530) begin
      errors++;
      $display("FAIL full_scale: valid=%b out_l=%0d out_r=%0d, expected 1 1530 1530", sample_valid, out_l, out_r);
    end
    checks++;
    if (out_l9 !== 9'sd255 || out_r9 !== 9'sd255) begin
      errors++;
      $display("FAIL full_scale_sat9: out_l9=%0d out_r9=%0d, expected 255 255", out_l9, out_r9);
    end
    repeat (3) @(negedge MCLK);
    checks++;
    if (n_valid - v0 !== 1 || sample_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_scale_single_pulse: pulses=%0d valid=%b, expected 1 0", n_valid - v0, sample_valid);
    end
  endtask

  task automatic test_neg_left_hold();
    int v0 = n_valid;
    for (int i = 0; i < 6; i++) do_tick(i == 0, 9'h000, 2'b10, 0);
    checks++;
    if (out_l !== -12'sd1536 || out_r !== 12'sd0) begin
      errors++;
      $display("FAIL neg_left: out_l=%0d out_r=%0d, expected -1536 0", out_l, out_r);
    end
    checks++;
    if (out_l9 !== -9'sd256 || out_r9 !== 9'sd0) begin
      errors++;
      $display("FAIL neg_left_sat9: out_l9=%0d out_r9=%0d, expected -256 0", out_l9, out_r9);
    end
    for (int i = 0; i < 20; i++) do_tick(1'b0, 9'h1FF, 2'b11, 0);
    @(negedge MCLK);
    checks++;
    if (out_l !== -12'sd1536 || out_r !== 12'sd0 || n_valid - v0 !== 1) begin
      errors++;
      $display("FAIL hold_20_ticks: out_l=%0d out_r=%0d pulses=%0d, expected -1536 0 1", out_l, out_r, n_valid - v0);
    end
  endtask

  task automatic test_zero_mixed();
    logic [8:0] vals [6] = '{9'h100, 9'h101, 9'h0FF, 9'h180, 9'h080, 9'h100};
    for (int i = 0; i < 6; i++) do_tick(i == 0, vals[i], 2'b01, 0);
    checks++;
    if (sample_valid !== 1'b1 || out_l !== 12'sd0 || out_r !== 12'sd0) begin
      errors++;
      $display("FAIL zero_mixed: valid=%b out_l=%0d out_r=%0d, expected 1 0 0", sample_valid, out_l, out_r);
    end
  endtask

  task automatic test_mid_frame_sync();
    int v0 = n_valid;
    int e0 = n_err;
    for (int i = 0; i < 3; i++) do_tick(i == 0, 9'h1FF, 2'b11, 0);
    checks++;
    if (n_err !== e0) begin
      errors++;
      $display("FAIL mid_sync_no_early_err: err_pulses=%0d, expected 0", n_err - e0);
    end
    do_tick(1'b1, 9'h1FF, 2'b11, 0);
    checks++;
    if (frame_err !== 1'b1 || out_l !== 12'sd0 || out_r !== 12'sd0) begin
      errors++;
      $display("FAIL mid_sync_err: err=%b out_l=%0d out_r=%0d, expected 1 0 0 (held)", frame_err, out_l, out_r);
    end
    for (int i = 0; i < 5; i++) do_tick(1'b0, 9'h1FF, 2'b11, 0);
    checks++;
    if (sample_valid !== 1'b1 || out_l !== 12'sd1530 || out_r !== 12'sd1530) begin
      errors++;
      $display("FAIL mid_sync_restart: valid=%b out_l=%0d out_r=%0d, expected 1 1530 1530", sample_valid, out_l, out_r);
    end
    @(negedge MCLK);
    checks++;
    if (n_err - e0 !== 1 || n_valid - v0 !== 1) begin
      errors++;
      $display("FAIL mid_sync_counts: err_pulses=%0d valid_pulses=%0d, expected 1 1", n_err - e0, n_valid - v0);
    end
  endtask

  // Sync landing on what would have been slot 6 restarts the frame without producing output.
  task automatic test_sync_at_slot5();
    int v0 = n_valid;
    for (int i = 0; i < 5; i++) do_tick(i == 0, 9'h000, 2'b11, 0);
    do_tick(1'b1, 9'h140, 2'b10, 0);
    checks++;
    if (frame_err !== 1'b1 || sample_valid !== 1'b0 || out_l !== 12'sd1530) begin
      errors++;
      $display("FAIL sync_slot5: err=%b valid=%b out_l=%0d, expected 1 0 1530", frame_err, sample_valid, out_l);
    end
    for (int i = 0; i < 5; i++) do_tick(1'b0, 9'h140, 2'b10, 0);
    checks++;
    if (out_l !== 12'sd384 || out_r !== 12'sd0 || n_valid - v0 !== 1) begin
      errors++;
      $display("FAIL sync_slot5_restart: out_l=%0d out_r=%0d pulses=%0d, expected 384 0 1", out_l, out_r, n_valid - v0);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [8:0] vals [6] = '{9'h1FF, 9'h000, 9'h140, 9'h120, 9'h0C0, 9'h110};
    logic [1:0] pans [6] = '{2'b11, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10};
    int v0;
    for (int i = 0; i < 6; i++) do_tick(i == 0, 9'h1FF, 2'b11, 0);
    for (int i = 0; i < 3; i++) do_tick(i == 0, 9'h1FF, 2'b11, 0);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (out_l !== 12'sd0 || out_r !== 12'sd0 || sample_valid !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: out_l=%0d out_r=%0d valid=%b err=%b, expected 0 0 0 0",
               out_l, out_r, sample_valid, frame_err);
    end
    repeat (2) @(negedge MCLK);
    reset = 1'b0;
    v0 = n_valid;
    for (int i = 0; i < 6; i++) do_tick(1'b0, 9'h1FF, 2'b11, 0);
    @(negedge MCLK);
    checks++;
    if (n_valid !== v0 || out_l !== 12'sd0) begin
      errors++;
      $display("FAIL reset_waits_sync: pulses=%0d out_l=%0d, expected 0 0", n_valid - v0, out_l);
    end
    // Gapped frame: two idle MCLK cycles before every tick.
    for (int i = 0; i < 6; i++) do_tick(i == 0, vals[i], pans[i], 2);
    checks++;
    if (sample_valid !== 1'b1 || out_l !== 12'sd367 || out_r !== 12'sd31) begin
      errors++;
      $display("FAIL gapped_frame: valid=%b out_l=%0d out_r=%0d, expected 1 367 31", sample_valid, out_l, out_r);
    end
    checks++;
    if (out_l9 !== 9'sd255 || out_r9 !== 9'sd31) begin
      errors++;
      $display("FAIL gapped_frame_sat9: out_l9=%0d out_r9=%0d, expected 255 31", out_l9, out_r9);
    end
  endtask

  task automatic test_back_to_back();
    int v0 = n_valid;
    for (int i = 0; i < 6; i++) do_tick(i == 0, 9'h101, 2'b10, 0);
    for (int i = 0; i < 6; i++) do_tick(i == 0, 9'h0FE, 2'b01, 0);
    checks++;
    if (out_l !== 12'sd0 || out_r !== -12'sd12 || n_valid - v0 !== 2) begin
      errors++;
      $display("FAIL back_to_back: out_l=%0d out_r=%0d pulses=%0d, expected 0 -12 2", out_l, out_r, n_valid - v0);
    end
  endtask

  initial begin
    test_reset();
    test_full_scale();
    test_neg_left_hold();
    test_zero_mixed();
    test_mid_frame_sync();
    test_sync_at_slot5();
    test_reset_mid_frame();
    test_back_to_back();
    repeat (2) @(negedge MCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
